// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control unit: state encoding, opcodes,
// ALU/immediate codes and the control-vector layout driven onto the datapath.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH
`ifdef CTRL_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    localparam logic [1:0] IMM_SEXT     = 2'b00;
    localparam logic [1:0] IMM_ZEXT     = 2'b01;
    localparam logic [1:0] IMM_HI16     = 2'b10;
    localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_ld_en;
        logic       ir_ld_en;
        logic       rf_wr_en;
        logic       rf_wr_data_sel;
        logic       rf_b_sel;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic [1:0] imm_ext;
        logic       mem_wr_en;
        logic       byte_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI,
            OP_B, OP_BEQ, OP_BNE, OP_LB, OP_LW, OP_SB, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // State entered from DECODE; unknown opcodes either trap or retire as a NOP.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:                                return EXEC_R;
            OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI: return EXEC_I;
            OP_LB, OP_LW, OP_SB, OP_SW:              return MEM_ADDR;
            OP_B, OP_BEQ, OP_BNE:                    return BRANCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:                                 return TRAP;
`else
            default:                                 return WB_ALU;
`endif
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational Moore output decode: current state plus latched opcode/func
// give the full datapath control vector (PC_Sel in BRANCH also uses ALU zero).
module control_decode
    import multicycle_control_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [3:0] func,
    input  logic       alu_zero,
    output ctrl_t      ctrl
);

    logic byte_op;

    assign byte_op = (opcode == OP_LB) || (opcode == OP_SB);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: ctrl.ir_ld_en = 1'b1;
            EXEC_R: begin
                ctrl.alu_func = func;
                ctrl.rf_b_sel = 1'b1;
            end
            EXEC_I: begin
                ctrl.alu_bin_sel = 1'b1;
                case (opcode)
                    OP_LUI:  ctrl.imm_ext = IMM_HI16;
                    OP_ANDI: begin
                        ctrl.alu_func = ALU_AND;
                        ctrl.imm_ext  = IMM_ZEXT;
                    end
                    OP_ORI: begin
                        ctrl.alu_func = ALU_OR;
                        ctrl.imm_ext  = IMM_ZEXT;
                    end
                    default: ;
                endcase
            end
            MEM_ADDR: begin
                ctrl.alu_bin_sel = 1'b1;
                ctrl.byte_op     = byte_op;
            end
            MEM_RD: ctrl.byte_op = byte_op;
            MEM_WR: begin
                ctrl.mem_wr_en  = 1'b1;
                ctrl.rf_b_sel   = 1'b1;
                ctrl.byte_op    = byte_op;
                ctrl.pc_ld_en   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            WB_ALU: begin
                // Unknown opcodes land here as a NOP: advance the PC but never write.
                ctrl.rf_wr_en   = is_known_op(opcode);
                ctrl.pc_ld_en   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            WB_MEM: begin
                ctrl.rf_wr_en       = 1'b1;
                ctrl.rf_wr_data_sel = 1'b1;
                ctrl.byte_op        = byte_op;
                ctrl.pc_ld_en       = 1'b1;
                ctrl.instr_done     = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_func   = ALU_SUB;
                ctrl.rf_b_sel   = 1'b1;
                ctrl.imm_ext    = IMM_SEXT_SH2;
                ctrl.pc_ld_en   = 1'b1;
                ctrl.instr_done = 1'b1;
                case (opcode)
                    OP_B:    ctrl.pc_sel = 1'b1;
                    OP_BEQ:  ctrl.pc_sel = alu_zero;
                    OP_BNE:  ctrl.pc_sel = !alu_zero;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: FSM state register, retired counter and
// output gating. Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes (adds Illegal).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int RETIRED_W = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [31:0]          Instr,
    input  logic                 ALU_zero,
    output logic                 PC_Sel,
    output logic                 PC_LdEn,
    output logic                 IR_LdEn,
    output logic                 RF_WrEn,
    output logic                 RF_WrData_sel,
    output logic                 RF_B_sel,
    output logic                 ALU_Bin_sel,
    output logic [3:0]           ALU_func,
    output logic [1:0]           ImmExt,
    output logic                 MEM_WrEn,
    output logic                 ByteOp,
    output logic                 Instr_Done,
    output logic [RETIRED_W-1:0] Retired
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 Illegal
`endif
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic [5:0] opcode;
    logic       unused_instr;

    assign opcode       = Instr[31:26];
    assign unused_instr = ^Instr[25:4];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:    state_nxt = DECODE;
            DECODE:   state_nxt = decode_target(opcode);
            EXEC_R:   state_nxt = WB_ALU;
            EXEC_I:   state_nxt = WB_ALU;
            MEM_ADDR: state_nxt = (opcode == OP_SB || opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   state_nxt = WB_MEM;
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP:     state_nxt = TRAP;
`endif
            default:  state_nxt = FETCH;
        endcase
    end

    control_decode u_decode (
        .state    (state),
        .opcode   (opcode),
        .func     (Instr[3:0]),
        .alu_zero (ALU_zero),
        .ctrl     (ctrl)
    );

    // Reset masks every output so nothing is enabled until Reset is released.
    assign ctrl_out = Reset ? ctrl : '0;

    assign PC_Sel        = ctrl_out.pc_sel;
    assign PC_LdEn       = ctrl_out.pc_ld_en;
    assign IR_LdEn       = ctrl_out.ir_ld_en;
    assign RF_WrEn       = ctrl_out.rf_wr_en;
    assign RF_WrData_sel = ctrl_out.rf_wr_data_sel;
    assign RF_B_sel      = ctrl_out.rf_b_sel;
    assign ALU_Bin_sel   = ctrl_out.alu_bin_sel;
    assign ALU_func      = ctrl_out.alu_func;
    assign ImmExt        = ctrl_out.imm_ext;
    assign MEM_WrEn      = ctrl_out.mem_wr_en;
    assign ByteOp        = ctrl_out.byte_op;
    assign Instr_Done    = ctrl_out.instr_done;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)               Retired <= '0;
        else if (ctrl.instr_done) Retired <= Retired + {{(RETIRED_W-1){1'b0}}, 1'b1};
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign Illegal = Reset && (state == TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected
// control vectors, a negedge monitor pops and compares them.
module tb_multicycle_control;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic [1:0]  ImmExt;
    logic        MEM_WrEn, ByteOp, Instr_Done;
    logic [31:0] Retired;
    logic        ill_act;

    string       qn[$];
    logic [15:0] qc[$];
    logic [31:0] qr[$];
    logic        qi[$];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_ret = 0;
    logic        exp_ill = 1'b0;

    always #5 Clk = ~Clk;

    multicycle_control #(.RETIRED_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
        .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .ImmExt(ImmExt), .MEM_WrEn(MEM_WrEn), .ByteOp(ByteOp),
        .Instr_Done(Instr_Done), .Retired(Retired)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .Illegal(ill_act)
`endif
    );
`ifndef CTRL_ILLEGAL_TRAP_EN
    assign ill_act = 1'b0;
`endif

    // {pcsel,pcld,irld,rfwr,wdsel,bsel,binsel,func[3:0],imm[1:0],memwr,byte,done}
    function automatic logic [15:0] mk(input logic pcsel, input logic pcld, input logic irld,
                                       input logic rfwr, input logic wdsel, input logic bsel,
                                       input logic binsel, input logic [3:0] fn, input logic [1:0] imm,
                                       input logic memwr, input logic byteop, input logic done);
        return {pcsel, pcld, irld, rfwr, wdsel, bsel, binsel, fn, imm, memwr, byteop, done};
    endfunction

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [5:0] fn);
        return {op, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    localparam logic [15:0] V_FETCH = 16'h2000;
    localparam logic [15:0] V_ZERO  = 16'h0000;

    // One cycle: queue the expectation, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [15:0] ctl);
        qn.push_back(name);
        qc.push_back(ctl);
        qr.push_back(exp_ret);
        qi.push_back(exp_ill);
        @(posedge Clk);
        #1;
        if (ctl[0] && Reset) exp_ret = exp_ret + 1;
    endtask

    task automatic do_r(input string name, input logic [5:0] fn);
        Instr = enc(6'b100000, fn);
        cyc({name, "_fetch"}, V_FETCH);
        cyc({name, "_decode"}, V_ZERO);
        cyc({name, "_exec"}, mk(0,0,0,0,0,1,0, fn[3:0], 2'b00, 0,0,0));
        cyc({name, "_wb"}, mk(0,1,0,1,0,0,0, 4'b0000, 2'b00, 0,0,1));
    endtask

    task automatic do_imm(input string name, input logic [5:0] op, input logic [3:0] fn, input logic [1:0] imm);
        Instr = enc(op, 6'd0);
        cyc({name, "_fetch"}, V_FETCH);
        cyc({name, "_decode"}, V_ZERO);
        cyc({name, "_exec"}, mk(0,0,0,0,0,0,1, fn, imm, 0,0,0));
        cyc({name, "_wb"}, mk(0,1,0,1,0,0,0, 4'b0000, 2'b00, 0,0,1));
    endtask

    task automatic do_load(input string name, input logic [5:0] op, input logic b);
        Instr = enc(op, 6'd0);
        cyc({name, "_fetch"}, V_FETCH);
        cyc({name, "_decode"}, V_ZERO);
        cyc({name, "_addr"}, mk(0,0,0,0,0,0,1, 4'b0000, 2'b00, 0,b,0));
        cyc({name, "_rd"}, mk(0,0,0,0,0,0,0, 4'b0000, 2'b00, 0,b,0));
        cyc({name, "_wb"}, mk(0,1,0,1,1,0,0, 4'b0000, 2'b00, 0,b,1));
    endtask

    task automatic do_store(input string name, input logic [5:0] op, input logic b);
        Instr = enc(op, 6'd0);
        cyc({name, "_fetch"}, V_FETCH);
        cyc({name, "_decode"}, V_ZERO);
        cyc({name, "_addr"}, mk(0,0,0,0,0,0,1, 4'b0000, 2'b00, 0,b,0));
        cyc({name, "_wr"}, mk(0,1,0,0,0,1,0, 4'b0000, 2'b00, 1,b,1));
    endtask

    task automatic do_br(input string name, input logic [5:0] op, input logic z, input logic pcsel);
        Instr = enc(op, 6'd0);
        ALU_zero = z;
        cyc({name, "_fetch"}, V_FETCH);
        cyc({name, "_decode"}, V_ZERO);
        cyc({name, "_branch"}, mk(pcsel,1,0,0,0,1,0, 4'b0001, 2'b11, 0,0,1));
        ALU_zero = 1'b0;
    endtask

    initial begin : monitor
        string       nm;
        logic [15:0] ec;
        logic [31:0] er;
        logic        ei;
        logic [15:0] ac;
        forever begin
            @(negedge Clk);
            if (qc.size() > 0) begin
                nm = qn.pop_front();
                ec = qc.pop_front();
                er = qr.pop_front();
                ei = qi.pop_front();
                ac = {PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                      ALU_func, ImmExt, MEM_WrEn, ByteOp, Instr_Done};
                n_vec++;
                if (ac !== ec || Retired !== er || ill_act !== ei) begin
                    n_err++;
                    $display("FAIL %s: got ctl=%b retired=%0d illegal=%b, want ctl=%b retired=%0d illegal=%b",
                             nm, ac, Retired, ill_act, ec, er, ei);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin : stimulus
        Reset    = 1'b0;
        Instr    = 32'h0;
        ALU_zero = 1'b0;
        @(posedge Clk);
        #1;
        Instr = enc(6'b011111, 6'd0);
        repeat (3) cyc("reset_hold", V_ZERO);
        Reset = 1'b1;

        do_r("add", 6'b110000);
        do_load("lw", 6'b001111, 1'b0);
        do_store("sw", 6'b011111, 1'b0);
        do_imm("ori", 6'b110011, 4'b0011, 2'b01);
        do_imm("lui", 6'b111001, 4'b0000, 2'b10);
        do_imm("andi", 6'b110010, 4'b0010, 2'b01);
        do_imm("li", 6'b111000, 4'b0000, 2'b00);
        do_r("sub", 6'b100001);
        do_load("lb", 6'b000011, 1'b1);
        do_store("sb", 6'b000111, 1'b1);
        do_br("beq_z1", 6'b000000, 1'b1, 1'b1);
        do_br("beq_z0", 6'b000000, 1'b0, 1'b0);
        do_br("bne_z1", 6'b000001, 1'b1, 1'b0);
        do_br("bne_z0", 6'b000001, 1'b0, 1'b1);
        do_br("b_z0",   6'b111111, 1'b0, 1'b1);

        // Abort a store in MEM_WR: write enable must vanish before the edge.
        Instr = enc(6'b011111, 6'd0);
        cyc("swabort_fetch", V_FETCH);
        cyc("swabort_decode", V_ZERO);
        cyc("swabort_addr", mk(0,0,0,0,0,0,1, 4'b0000, 2'b00, 0,0,0));
        Reset   = 1'b0;
        exp_ret = 0;
        cyc("swabort_rst0", V_ZERO);
        cyc("swabort_rst1", V_ZERO);
        Reset = 1'b1;
        do_r("add_after_rst", 6'b110000);

        Instr = enc(6'b010101, 6'd0);
        cyc("illegal_fetch", V_FETCH);
        cyc("illegal_decode", V_ZERO);
`ifdef CTRL_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
        repeat (3) cyc("illegal_trap", V_ZERO);
        Reset   = 1'b0;
        exp_ill = 1'b0;
        exp_ret = 0;
        cyc("trap_rst", V_ZERO);
        Reset = 1'b1;
        do_r("add_after_trap", 6'b110000);
`else
        cyc("illegal_nop", mk(0,1,0,0,0,0,0, 4'b0000, 2'b00, 0,0,1));
        do_r("add_after_nop", 6'b110000);
`endif

        @(negedge Clk);
        if (qc.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", qc.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the processor datapath. Sequences the fetch stage (PC register, PC+4 / branch-target mux, instruction memory), register file, ALU stage and data-memory stage. It decodes the latched instruction word, walks a Moore FSM through each instruction's phases and drives every datapath enable and select. Sits beside the datapath top level; the datapath holds no control state of its own.

## Interface
- RETIRED_W, 32, width of the retired-instruction counter
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low; forces FSM to FETCH and counter to 0
- Instr  in  32  IR contents; opcode = Instr[31:26], func = Instr[5:0]
- ALU_zero  in  1  ALU zero flag, valid combinationally in BRANCH
- PC_Sel  out  1  0 = PC+4, 1 = PC+4+(SignExt(Imm)<<2)
- PC_LdEn  out  1  PC register load enable
- IR_LdEn  out  1  instruction register load enable
- RF_WrEn  out  1  register-file write enable
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data
- RF_B_sel  out  1  0 = read port B addresses rt, 1 = rd
- ALU_Bin_sel  out  1  0 = RF B, 1 = extended immediate
- ALU_func  out  4  ALU operation code
- ImmExt  out  2  00 sign-ext, 01 zero-fill, 10 <<16 zero-fill, 11 sign-ext<<2
- MEM_WrEn  out  1  data-memory write enable
- ByteOp  out  1  1 = byte access (lb/sb)
- Instr_Done  out  1  one-cycle pulse in an instruction's final state
- Retired  out  RETIRED_W  count of completed instructions
- Illegal  out  1  sticky illegal-opcode flag (CTRL_ILLEGAL_TRAP_EN only)

## Operation
- Opcodes: R-type 100000; li 111000, lui 111001, addi 110000, andi 110010, ori 110011; b 111111, beq 000000, bne 000001; lb 000011, lw 001111, sb 000111, sw 011111.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH (plus TRAP when configured).
- FETCH: IR_LdEn=1 -> DECODE. DECODE: all enables 0, RF_B_sel=0; selects next state from opcode.
- R-type: EXEC_R (ALU_func=func[3:0], ALU_Bin_sel=0, RF_B_sel=1) -> WB_ALU.
- li/lui/addi/andi/ori: EXEC_I (ALU_Bin_sel=1; ALU_func add 0000 for li/lui/addi with rs forced to r0 by datapath for li/lui, and 0010 for andi, 0011 for ori; ImmExt 00/10/00/01/01) -> WB_ALU.
- lb/lw/sb/sw: MEM_ADDR (add, ImmExt=00, ALU_Bin_sel=1) -> MEM_RD for loads, MEM_WR for stores. MEM_RD -> WB_MEM (RF_WrData_sel=1, RF_WrEn=1).
- MEM_WR: MEM_WrEn=1, RF_B_sel=1.
- ByteOp=1 throughout lb/sb.
- b/beq/bne: BRANCH (ALU_func=0001 sub, RF_B_sel=1). PC_Sel = 1 for b, ALU_zero for beq, !ALU_zero for bne.
- Final states (WB_ALU, WB_MEM, MEM_WR, BRANCH): PC_LdEn=1, Instr_Done=1, Retired+1, next FETCH. Non-branch final states drive PC_Sel=0.
- Retired wraps modulo 2^RETIRED_W.
- Undefined R-type func codes are not checked; they pass func[3:0] through.

## Timing
- Moore outputs decoded from the state register only, except PC_Sel in BRANCH, which depends on ALU_zero.
- Cycles per instruction: branch 3; R/immediate 4; store 4; load 5.
- Reset asserted mid-instruction: state returns to FETCH immediately. All enables read 0 while Reset is low; IR_LdEn rises to 1 only after release. Partial writes of the aborted instruction are not committed after reset.
- First rising edge after Reset release loads IR at PC 0.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an unknown opcode in DECODE goes to TRAP. TRAP holds all enables 0 and sets Illegal=1 until Reset; Retired is not incremented.
- Not defined: an unknown opcode takes DECODE -> WB_ALU with RF_WrEn forced 0, i.e. a 3-cycle NOP that advances the PC and counts as retired. The Illegal port is absent.

## Structure
- Shared package: state encoding, opcode constants, ALU_func codes, ImmExt codes.
- One sub-module, control_decode: combinational state+Instr -> output vector. The FSM register and counter stay in multicycle_control.

## Test plan
- Reset low 3 cycles, release -> all enables 0 during reset; IR_LdEn=1 first cycle after; Retired=0.
- add (func 110000) -> states FETCH, DECODE, EXEC_R, WB_ALU; RF_WrEn and PC_LdEn high in cycle 4 only; Retired=1.
- lw then sw -> 5 + 4 cycles; MEM_WrEn high only in the sw cycle 4; RF_WrData_sel=1 in lw cycle 5.
- beq with ALU_zero=1 -> PC_Sel=1 in cycle 3. Repeat with ALU_zero=0 -> PC_Sel=0. bne gives the inverse.
- Reset pulsed during MEM_WR -> MEM_WrEn drops immediately; FSM restarts at FETCH.
- Opcode 010101: with the macro -> TRAP, Illegal=1, PC_LdEn stays 0; without it -> 3-cycle NOP, RF_WrEn=0.
